// File: rtl/bcd_pkg.sv
// Shared types and helpers for the streaming binary-to-BCD converter.
package bcd_pkg;

  localparam int BCD_NIBBLE_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // ceil(w * log10(2)) via a fixed-point approximation of log10(2).
  function automatic int digits_for_width(int w);
    return (w * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble add-3 correction for one BCD nibble.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_NIBBLE_W-1:0] nib,
  output logic [BCD_NIBBLE_W-1:0] adj
);

  // 4-bit add, no carry out: a corrected nibble never exceeds 12.
  assign adj = (nib >= 4'd5) ? nib + 4'd3 : nib;

endmodule

// File: rtl/bin_to_bcd_stream.sv
// Sequential double-dabble converter with valid/ready on both sides, one bit per clock.
// Define BCD_SIGNED_EN to treat in_data as two's complement and report the sign on out_neg.
module bin_to_bcd_stream
  import bcd_pkg::*;
#(
  parameter  int IN_WIDTH = 16,
  parameter  int DIGITS   = 5,
  localparam int CNT_W    = $clog2(IN_WIDTH + 1),
  localparam int ND_W     = $clog2(DIGITS + 1)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [IN_WIDTH-1:0]            in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [BCD_NIBBLE_W*DIGITS-1:0] out_bcd,
  output logic [ND_W-1:0]                out_ndigits,
  output logic                           out_neg
);

  localparam int SW = BCD_NIBBLE_W * DIGITS;
`ifdef BCD_SIGNED_EN
  localparam int MAG_W = IN_WIDTH - 1;
`else
  localparam int MAG_W = IN_WIDTH;
`endif

  if (DIGITS < digits_for_width(MAG_W)) begin : g_digits_chk
    $error("bin_to_bcd_stream: DIGITS too small for IN_WIDTH");
  end

  state_t              state, state_nxt;
  logic [IN_WIDTH-1:0] bin;
  logic [IN_WIDTH-1:0] mag;
  logic [SW-1:0]       scratch, adjusted, scratch_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [ND_W-1:0]     nd_nxt;
  logic                last;

  for (genvar d = 0; d < DIGITS; d++) begin : g_dig
    bcd_digit_adj u_adj (
      .nib (scratch[d*BCD_NIBBLE_W +: BCD_NIBBLE_W]),
      .adj (adjusted[d*BCD_NIBBLE_W +: BCD_NIBBLE_W])
    );
  end

  // Shift drops the top scratch bit; the DIGITS check guarantees it is zero.
  assign scratch_nxt = (adjusted << 1) | SW'(bin[IN_WIDTH-1]);
  assign last        = (cnt == CNT_W'(IN_WIDTH - 1));

`ifdef BCD_SIGNED_EN
  logic sign;
  assign mag = in_data[IN_WIDTH-1] ? -in_data : in_data;
`else
  assign mag     = in_data;
  assign out_neg = 1'b0;
`endif

  always_comb begin
    nd_nxt = ND_W'(1);
    for (int i = 1; i < DIGITS; i++)
      if (scratch_nxt[i*BCD_NIBBLE_W +: BCD_NIBBLE_W] != '0) nd_nxt = ND_W'(i + 1);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_CONV;
      end
      S_CONV: if (last) state_nxt = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bin         <= '0;
      scratch     <= '0;
      cnt         <= '0;
      out_bcd     <= '0;
      out_ndigits <= '0;
`ifdef BCD_SIGNED_EN
      sign        <= 1'b0;
      out_neg     <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          bin     <= mag;
          scratch <= '0;
          cnt     <= '0;
`ifdef BCD_SIGNED_EN
          sign    <= in_data[IN_WIDTH-1];
`endif
        end
        S_CONV: begin
          bin     <= bin << 1;
          scratch <= scratch_nxt;
          cnt     <= cnt + CNT_W'(1);
          if (last) begin
            out_bcd     <= scratch_nxt;
            out_ndigits <= nd_nxt;
`ifdef BCD_SIGNED_EN
            out_neg     <= sign;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_stream.sv
// Directed bench: 16-bit/5-digit instance for handshake, backpressure and reset cases,
// 8-bit/3-digit instance for a back-to-back sweep. Honours BCD_SIGNED_EN.
module tb_bin_to_bcd_stream;

  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        in_valid = 0, out_ready = 0, in_ready, out_valid, out_neg;
  logic [15:0] in_data = '0;
  logic [19:0] out_bcd;
  logic [2:0]  out_ndigits;

  logic        in_valid8 = 0, out_ready8 = 1, in_ready8, out_valid8, out_neg8;
  logic [7:0]  in_data8 = '0;
  logic [11:0] out_bcd8;
  logic [1:0]  out_ndigits8;

  bin_to_bcd_stream #(.IN_WIDTH(16), .DIGITS(5)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_bcd(out_bcd),
    .out_ndigits(out_ndigits), .out_neg(out_neg)
  );

  bin_to_bcd_stream #(.IN_WIDTH(8), .DIGITS(3)) u_dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_bcd(out_bcd8),
    .out_ndigits(out_ndigits8), .out_neg(out_neg8)
  );

  int errors = 0, checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] to_bcd(input int m);
    logic [31:0] r = '0;
    for (int i = 0; i < 8; i++) begin
      r[i*4 +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  function automatic int ndig(input int m);
    int n = 1;
    while (m >= 10) begin
      n++;
      m = m / 10;
    end
    return n;
  endfunction

  // Accept one word and wait (bounded) for out_valid; lat counts edges after the accept edge.
  task automatic run16(input logic [15:0] v, output int lat);
    in_data  = v;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic conv16(input string tag, input logic [15:0] v, input logic [19:0] eb,
                        input int en, input logic eneg);
    int lat;
    run16(v, lat);
    check({tag, "_lat"}, lat, 16);
    check({tag, "_bcd"}, out_bcd, eb);
    check({tag, "_nd"}, out_ndigits, en);
    check({tag, "_neg"}, out_neg, eneg);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_idle"}, in_ready, 1);
  endtask

  initial begin
    int lat, seen, prev, mag;
    logic neg;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_bcd", out_bcd, 0);
    check("rst_nd", out_ndigits, 0);
    check("rst_neg", out_neg, 0);

    conv16("zero", 16'd0, 20'h00000, 1, 1'b0);
`ifdef BCD_SIGNED_EN
    conv16("neg1", 16'hFFFF, 20'h00001, 1, 1'b1);
    conv16("min", 16'h8000, 20'h32768, 5, 1'b1);
    conv16("max", 16'h7FFF, 20'h32767, 5, 1'b0);
`else
    conv16("all1", 16'hFFFF, 20'h65535, 5, 1'b0);
`endif

    // Backpressure: result held, a second word must not be taken
    run16(16'd1234, lat);
    check("bp_lat", lat, 16);
    in_data  = 16'd777;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", out_valid, 1);
      check("bp_bcd", out_bcd, 20'h01234);
      check("bp_nd", out_ndigits, 4);
      check("bp_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_ready_after", in_ready, 1);
    check("bp_valid_after", out_valid, 0);
    check("bp_hold_bcd", out_bcd, 20'h01234);
    @(posedge clk); #1;
    check("bp_no_accept", in_ready, 1);

    // Reset during conversion
    in_data  = 16'd9999;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rm_in_ready", in_ready, 1);
    check("rm_valid", out_valid, 0);
    check("rm_bcd", out_bcd, 0);
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    check("rm_no_emit", seen, 0);
    conv16("v42", 16'd42, 20'h00042, 2, 1'b0);

    // Reset wins over a simultaneous in_valid
    in_data  = 16'd5;
    in_valid = 1'b1;
    reset    = 1'b1;
    @(posedge clk); #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    check("rv_bcd_cleared", out_bcd, 0);
    @(posedge clk); #1;
    check("rv_in_ready", in_ready, 1);
    check("rv_valid", out_valid, 0);

    // 8-bit back-to-back sweep with out_ready held high
    prev = 0;
    for (int v = 0; v < 256; v++) begin
      in_data8  = 8'(v);
      in_valid8 = 1'b1;
      @(posedge clk); #1;
      in_valid8 = 1'b0;
      if (v > 0) check("sw_period", cyc - prev, 10);
      prev = cyc;
      lat = 0;
      while (!out_valid8 && lat < 50) begin
        @(posedge clk); #1;
        lat++;
      end
      check("sw_lat", lat, 8);
`ifdef BCD_SIGNED_EN
      neg = (v >= 128);
      mag = neg ? 256 - v : v;
`else
      neg = 1'b0;
      mag = v;
`endif
      check("sw_bcd", out_bcd8, to_bcd(mag));
      check("sw_nd", out_ndigits8, ndig(mag));
      check("sw_neg", out_neg8, neg);
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
